// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : dff_pipe
//  Brief    : Parameterised register pipeline with per-stage valid bits,
//             stall (en), flush and an occupancy counter with full flag.
//  Revision : 1.0  initial release
// ============================================================================
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int C_CNT_W = $clog2(DEPTH + 1);

  // Parameter legality is enforced while elaborating, before any logic exists.
  generate
    if ((WIDTH < 1) || (WIDTH > 64)) begin : g_bad_width
      $error("dff_pipe: WIDTH must be in 1..64");
    end
    if ((DEPTH < 1) || (DEPTH > 32)) begin : g_bad_depth
      $error("dff_pipe: DEPTH must be in 1..32");
    end
  endgenerate

  logic [WIDTH-1:0]   r_data [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [C_CNT_W-1:0] r_count;

  // Stage data: reset loads RESET_VAL; flush leaves data untouched; an
  // enabled edge shifts every stage regardless of the valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
    end else if (!flush && en) begin
      r_data[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
      end
    end
  end

  // Valid bits and occupancy: the counter tracks the population of r_valid
  // incrementally (+ incoming valid, - valid leaving the last stage), so it
  // can never leave 0..DEPTH; a full pipe taking a new sample drops the oldest.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (en) begin
      r_valid[0] <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
      r_count <= r_count + C_CNT_W'(d_valid) - C_CNT_W'(r_valid[DEPTH-1]);
    end
  end

  assign q       = r_data[DEPTH-1];
  assign q_valid = r_valid[DEPTH-1];
  assign count   = r_count;
  assign full    = (r_count == C_CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data bits per stage (legal range 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of register stages and cycles of latency (legal range 1..32).
REQ-003 The block SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data stage on reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: advance enable; 0 = stall (hold all stages).
REQ-007 The block SHALL have port flush, input, 1 bit: invalidate all stages.
REQ-008 The block SHALL have port d, input, WIDTH bits: data into stage 0.
REQ-009 The block SHALL have port d_valid, input, 1 bit: qualifier for d.
REQ-010 The block SHALL have port q, output, WIDTH bits: data of stage DEPTH-1, driven directly from a register.
REQ-011 The block SHALL have port q_valid, output, 1 bit: valid bit of stage DEPTH-1.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH+1) bits: number of stages currently holding valid data.
REQ-013 The block SHALL have port full, output, 1 bit: high when count == DEPTH.

Function
REQ-014 Each stage SHALL hold one WIDTH-bit data register and one valid bit.
REQ-015 Update priority at each rising edge SHALL be reset, then flush, then en, then hold.
REQ-016 With en=1 and flush=0, the block SHALL load stage 0 with d and d_valid, and stage i with stage i-1 for i = 1..DEPTH-1.
REQ-017 Data SHALL be shifted regardless of d_valid; the valid bits alone mark occupancy.
REQ-018 With en=0 and flush=0, every data register, valid bit and count SHALL hold.
REQ-019 With flush=1, all valid bits SHALL clear and count SHALL become 0, data registers SHALL hold, and d/d_valid SHALL NOT be captured, regardless of en.
REQ-020 Latency SHALL be exactly DEPTH enabled edges: a sample captured on enabled edge k appears on q/q_valid after enabled edge k+DEPTH-1. Stalled edges do not count.
REQ-021 On an enabled, unflushed edge, count SHALL update to count + d_valid - (valid bit of stage DEPTH-1 before the edge).
REQ-022 count SHALL never exceed DEPTH or underflow below 0.
REQ-023 With count == DEPTH, an enabled edge with d_valid=1 SHALL drop the oldest sample; count stays DEPTH and full stays 1.
REQ-024 full SHALL be derived combinationally from count.
REQ-025 DEPTH=1 SHALL behave as a single enabled D flip-flop with a valid bit; latency is 1.
REQ-026 The block SHALL contain no combinational path from any input to q, q_valid, count or full.
REQ-027 Out-of-range WIDTH or DEPTH SHALL cause an elaboration-time error.

Reset
REQ-028 Asserting reset at a rising edge SHALL load all data stages with RESET_VAL and clear all valid bits, so q=RESET_VAL, q_valid=0, count=0 and full=0 after that edge.
REQ-029 Reset SHALL take effect even mid-stream or while en=0 or flush=1, and SHALL override both.
REQ-030 The first enabled edge after reset deasserts SHALL capture d normally.

Verification
REQ-031 Reset (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5): hold reset for 2 edges with en=1, d_valid=1 -> q=8'hA5, q_valid=0, count=0 throughout and after the release edge.
REQ-032 Latency: en=1, drive d=1,2,3,4,5 with d_valid=1 on consecutive edges -> q_valid rises after the 4th edge with q=1, then q=2,3,4,5 on following edges; count goes 1,2,3,4 and then stays 4 with full=1.
REQ-033 Stall: pipeline holds 1..4, en=0 for 3 edges while d changes -> q, count and all stages unchanged; resume en=1 -> q continues 2,3,4 in order.
REQ-034 Bubbles: d_valid pattern 1,0,1,0 with d=10,11,12,13 -> q_valid pattern 1,0,1,0 with q=10 then 12 on the valid cycles; count never exceeds 2.
REQ-035 Flush with en=1 and d_valid=1 while full -> next edge count=0, q_valid=0, q data unchanged, d not captured; a subsequent valid sample emerges after DEPTH edges.
REQ-036 Parameter sweep (DEPTH=1, WIDTH=1 and DEPTH=32, WIDTH=64) against a reference queue model, with random en, flush and d_valid over 10k cycles -> q, q_valid and count match the model every cycle.
